// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_rmw_ctrl_if.sv
// Pipeline-side request/response channel of the load/store unit.
interface lsu_rmw_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load lane extract/extend and sub-word store merge
// into a full memory word (little-endian lanes).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  lsu_size_t   size,
    input  logic        is_signed,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        byte_val  = rdata[{lane, 3'b000} +: 8];
        half_val  = rdata[{lane[1], 4'b0000} +: 16];
        load_data = rdata;
        merged    = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{is_signed & byte_val[7]}}, byte_val};
                merged    = rdata;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{is_signed & half_val[15]}}, half_val};
                merged    = rdata;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit controller: one request in flight, word-addressed memory,
// read-modify-write for sub-word stores. Optional feature: MISALIGN_TRAP_EN.
module lsu_rmw_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_rmw_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_eh,
    output logic              mem_eb,
    input  logic [DATA_W-1:0] mem_rdata
);
    lsu_state_t        state, state_d;
    logic [ADDR_W-1:0] widx_q;
    logic [1:0]        lane_q;
    lsu_size_t         size_q;
    logic              we_q, signed_q;
    logic [31:0]       wdata_q, rmw_q, rsp_rdata_q;
    logic              rsp_err_q;

    lsu_size_t   in_size;
    logic [1:0]  in_lane;
    logic        in_err;
    logic        hs;
    logic [31:0] align_rdata, load_data, merged;

    assign hs = bus.req_valid && bus.req_ready;

    // Incoming request decode: either trap misaligned/reserved requests or force them aligned.
    always_comb begin
        in_size = lsu_size_t'(bus.req_size);
        in_lane = bus.req_addr[1:0];
        in_err  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (in_size)
            SIZE_HALF: in_err = in_lane[0];
            SIZE_WORD: in_err = |in_lane;
            SIZE_RSVD: in_err = 1'b1;
            default:   ;
        endcase
`else
        case (in_size)
            SIZE_HALF: in_lane[0] = 1'b0;
            SIZE_WORD, SIZE_RSVD: begin
                in_size = SIZE_WORD;
                in_lane = 2'b00;
            end
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    if (in_err)                                 state_d = ST_RESP;
                    else if (bus.req_we && in_size != SIZE_WORD) state_d = ST_RMW_RD;
                    else                                        state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_q      <= '0;
            lane_q      <= '0;
            size_q      <= SIZE_BYTE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            rmw_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs) begin
                        widx_q   <= bus.req_addr[ADDR_W+1:2];
                        lane_q   <= in_lane;
                        size_q   <= in_size;
                        we_q     <= bus.req_we;
                        signed_q <= bus.req_signed;
                        wdata_q  <= bus.req_wdata;
                        if (in_err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? 32'h0 : load_data;
                end
                ST_RMW_RD: rmw_q <= mem_rdata;
                ST_RMW_WR: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // The merge works on the word captured in RMW_RD; loads extract straight from memory.
    assign align_rdata = (state == ST_RMW_WR) ? rmw_q : mem_rdata;

    lsu_lane_align u_align (
        .lane      (lane_q),
        .size      (size_q),
        .is_signed (signed_q),
        .rdata     (align_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_ACCESS: if (we_q) begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
            end
            ST_RMW_WR: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
            end
            default: ;
        endcase
    end

    assign mem_addr      = widx_q;
    assign mem_eh        = 1'b0;
    assign mem_eb        = 1'b0;
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Self-checking bench for lsu_rmw_ctrl: directed scenarios plus random traffic
// against a word-array reference model. Honours MISALIGN_TRAP_EN like the DUT.
module tb_lsu_rmw_ctrl;
    import lsu_pkg::*;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_eh, mem_eb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    lsu_rmw_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_rmw_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_eh    (mem_eh),
        .mem_eb    (mem_eb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: applies the access rules to ref_mem and predicts the response.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rdata,
                              output int lat, output int we_cnt, output int widx);
        int unsigned a, sz, lane, word, v, mask;
        a = addr; sz = size; err = 1'b0; rdata = 0;
`ifdef MISALIGN_TRAP_EN
        if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) err = 1'b1;
`else
        if (sz == 3) sz = 2;
        if (sz == 1) a = a - (a % 2);
        if (sz == 2) a = a - (a % 4);
`endif
        widx = (a / 4) % 1024;
        lane = a % 4;
        if (err) begin
            lat = 1; we_cnt = 0;
            return;
        end
        word = ref_mem[widx];
        if (sz == 0) mask = 32'hFF << (8 * lane);
        else if (sz == 1) mask = 32'hFFFF << (8 * lane);
        else mask = 32'hFFFF_FFFF;
        if (we) begin
            ref_mem[widx] = (word & ~mask) | ((wdata << (8 * lane)) & mask);
            we_cnt = 1;
            lat = (sz == 2) ? 2 : 3;
        end else begin
            v = (word & mask) >> (8 * lane);
            if (sgn && sz == 0 && v >= 128)   v = v + 32'hFFFF_FF00;
            if (sgn && sz == 1 && v >= 32768) v = v + 32'hFFFF_0000;
            rdata = v;
            we_cnt = 0;
            lat = 2;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [11:0] addr, input logic [31:0] wdata, input logic hold,
                          output logic [31:0] r_data, output logic r_err);
        logic        e_err, got, ready_bad;
        logic [31:0] e_rdata;
        int          e_lat, e_we, widx, lat, we_cnt, waited;
        ref_access(we, size, sgn, addr, wdata, e_err, e_rdata, e_lat, e_we, widx);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_wait", 32'(waited >= 20), 32'd0);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        got = 1'b0; lat = 0; we_cnt = 0; ready_bad = 1'b0;
        r_data = 32'h0; r_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) we_cnt++;
            if (bus.req_ready) ready_bad = 1'b1;
            if (bus.rsp_valid) begin
                got = 1'b1; lat = c;
                r_data = bus.rsp_rdata; r_err = bus.rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", lat, e_lat);
        check("rsp_err", 32'(r_err), 32'(e_err));
        check("rsp_rdata", r_data, e_rdata);
        check("mem_we_cycles", we_cnt, e_we);
        check("busy_ready_low", 32'(ready_bad), 32'd0);
        @(posedge clk); #1;
        check("rsp_single_cycle", 32'(bus.rsp_valid), 32'd0);
        check("ready_after_resp", 32'(bus.req_ready), 32'd1);
        check("rdata_held", bus.rsp_rdata, r_data);
        if (we) check("mem_word", mem[widx], ref_mem[widx]);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          bad_we;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state.
        #12;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("mem_eh_eb", {30'd0, mem_eh, mem_eb}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Preload the words used by the test through word stores.
        for (int w = 0; w < 17; w++) begin
            logic [11:0] a;
            a = (w == 16) ? 12'hFFC : 12'(w * 4);
            do_req(1'b1, 2'b10, 1'b0, a, $urandom, 1'b0, r, e);
        end

        // Reset during RMW_RD aborts the store without touching memory.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_addr = 12'h031; bus.req_wdata = 32'h0000_00AB;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rmw_rd_no_we", 32'(mem_we), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bad_we = 0;
        for (int c = 0; c < 3; c++) begin
            if (mem_we) bad_we++;
            @(posedge clk); #1;
        end
        check("midrst_we_count", bad_we, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (mem_we) bad_we++;
        check("midrst_we_after", bad_we, 0);
        check("midrst_word", mem[12], ref_mem[12]);

        // Word store then word load.
        do_req(1'b1, 2'b10, 1'b0, 12'h030, 32'h9099_88FF, 1'b0, r, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h030, 32'h0, 1'b0, r, e);
        check("t2_word_load", r, 32'h9099_88FF);

        // Byte loads, signed and unsigned.
        do_req(1'b0, 2'b00, 1'b1, 12'h033, 32'h0, 1'b0, r, e);
        check("t3_byte_signed", r, 32'hFFFF_FF90);
        do_req(1'b0, 2'b00, 1'b0, 12'h030, 32'h0, 1'b0, r, e);
        check("t3_byte_unsigned", r, 32'h0000_00FF);

        // Half store merges into the upper lane.
        do_req(1'b1, 2'b01, 1'b0, 12'h032, 32'h0000_1234, 1'b0, r, e);
        check("t4_merged_word", mem[12], 32'h1234_88FF);

        // Half load at an odd address.
        do_req(1'b0, 2'b01, 1'b0, 12'h031, 32'h0, 1'b0, r, e);
`ifdef MISALIGN_TRAP_EN
        check("t5_trap_err", 32'(e), 32'd1);
        check("t5_trap_rdata", r, 32'd0);
`else
        check("t5_aligned_half", r, 32'h0000_88FF);
        check("t5_no_err", 32'(e), 32'd0);
`endif

        // Back-to-back with req_valid held high.
        do_req(1'b1, 2'b00, 1'b0, 12'h008, 32'h0000_005A, 1'b1, r, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, 1'b1, r, e);
        do_req(1'b1, 2'b01, 1'b0, 12'h00A, 32'h0000_C3C3, 1'b1, r, e);
        do_req(1'b0, 2'b01, 1'b1, 12'h00A, 32'h0, 1'b1, r, e);
        check("t6_half_signed", r, 32'hFFFF_C3C3);
        bus.req_valid = 1'b0;

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            int unsigned widx;
            logic [11:0] a;
            widx = ($urandom_range(0, 16) == 16) ? 1023 : $urandom_range(0, 15);
            a = {widx[9:0], 2'($urandom_range(0, 3))};
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   1'($urandom_range(0, 3) == 0), r, e);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) check("final_mem", mem[w], ref_mem[w]);
        check("final_mem_top", mem[1023], ref_mem[1023]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
